// File: rtl/int_to_float_converter.sv
// Iterative 32-bit signed/unsigned integer to IEEE-754 single converter (FCVT.S.W / FCVT.S.WU).
// Valid/ready on both sides, one operand in flight, round-to-nearest-even.
module int_to_float_converter #(
  parameter bit FAST_NORM = 1'b0
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] int_operand,
  input  logic        is_signed,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] float_result,
  output logic        inexact
);

  // state | meaning
  // IDLE  | waiting for an operand, in_ready=1
  // NORM  | shifting magnitude left until bit 31 is set (zero operand exits to DONE)
  // ROUND | round-to-nearest-even on the normalised magnitude, register result
  // DONE  | result presented, waiting for out_ready
  typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

  state_t      state;
  logic        sign;
  logic [31:0] mag;
  logic [5:0]  lz;

  logic        op_sign;
  logic [31:0] op_mag;
  logic [22:0] mant;
  logic        guard;
  logic        sticky;
  logic        round_up;
  logic [23:0] mant_inc;
  logic [7:0]  exp_base;
  logic [7:0]  exp_rnd;

  always_comb begin
    op_sign  = is_signed & int_operand[31];
    op_mag   = op_sign ? (~int_operand + 32'd1) : int_operand;
    mant     = mag[30:8];
    guard    = mag[7];
    sticky   = |mag[6:0];
    round_up = guard & (sticky | mant[0]);
    mant_inc = {1'b0, mant} + {23'd0, round_up};
    exp_base = 8'd158 - {2'b00, lz};
    // a carry out of the mantissa leaves mant_inc[22:0] at zero and bumps the exponent
    exp_rnd  = exp_base + {7'd0, mant_inc[23]};
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state        <= IDLE;
      sign         <= 1'b0;
      mag          <= 32'd0;
      lz           <= 6'd0;
      in_ready     <= 1'b1;
      out_valid    <= 1'b0;
      float_result <= 32'd0;
      inexact      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sign     <= op_sign;
            mag      <= op_mag;
            lz       <= 6'd0;
            in_ready <= 1'b0;
            state    <= NORM;
          end
        end
        NORM: begin
          // zero takes one registered step so its result appears one cycle after accept
          if (mag == 32'd0) begin
            float_result <= 32'd0;
            inexact      <= 1'b0;
            out_valid    <= 1'b1;
            state        <= DONE;
          end else if (mag[31]) begin
            state <= ROUND;
          end else if (FAST_NORM && (mag[31:24] == 8'd0)) begin
            mag <= {mag[23:0], 8'd0};
            lz  <= lz + 6'd8;
          end else begin
            mag <= {mag[30:0], 1'b0};
            lz  <= lz + 6'd1;
          end
        end
        ROUND: begin
          float_result <= {sign, exp_rnd, mant_inc[22:0]};
          inexact      <= guard | sticky;
          out_valid    <= 1'b1;
          state        <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_int_to_float_converter.sv
// Self-checking bench: directed corner cases plus random operands against an arithmetic
// reference model, on one instance of each normalisation mode.
module tb_int_to_float_converter;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        sel = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] int_operand = 32'd0;
  logic        is_signed = 1'b0;
  logic        out_ready = 1'b0;

  logic        in_ready_s, out_valid_s, inexact_s;
  logic        in_ready_f, out_valid_f, inexact_f;
  logic [31:0] float_result_s, float_result_f;

  logic        in_valid_s, in_valid_f, out_ready_s, out_ready_f;
  logic        in_ready_o, out_valid_o, inexact_o;
  logic [31:0] float_result_o;

  int n_checks = 0;
  int n_fail = 0;

  always #5 CLK = ~CLK;

  assign in_valid_s     = in_valid & ~sel;
  assign in_valid_f     = in_valid & sel;
  assign out_ready_s    = out_ready & ~sel;
  assign out_ready_f    = out_ready & sel;
  assign in_ready_o     = sel ? in_ready_f : in_ready_s;
  assign out_valid_o    = sel ? out_valid_f : out_valid_s;
  assign inexact_o      = sel ? inexact_f : inexact_s;
  assign float_result_o = sel ? float_result_f : float_result_s;

  int_to_float_converter #(.FAST_NORM(1'b0)) u_dut_s (
    .CLK(CLK), .RESET(RESET), .in_valid(in_valid_s), .in_ready(in_ready_s),
    .int_operand(int_operand), .is_signed(is_signed), .out_valid(out_valid_s),
    .out_ready(out_ready_s), .float_result(float_result_s), .inexact(inexact_s)
  );

  int_to_float_converter #(.FAST_NORM(1'b1)) u_dut_f (
    .CLK(CLK), .RESET(RESET), .in_valid(in_valid_f), .in_ready(in_ready_f),
    .int_operand(int_operand), .is_signed(is_signed), .out_valid(out_valid_f),
    .out_ready(out_ready_f), .float_result(float_result_f), .inexact(inexact_f)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Value-level model: locate the leading one, round the value to 24 significant bits.
  function automatic void ref_model(input logic [31:0] op, input bit sg, input bit fast,
                                    output logic [31:0] res, output bit inx, output int lat);
    bit neg;
    longint unsigned m, q, rem, half;
    int p, sh, lzc;
    neg = sg && op[31];
    m = neg ? (64'h1_0000_0000 - {32'd0, op}) : {32'd0, op};
    if (m == 0) begin
      res = 32'd0; inx = 1'b0; lat = 1;
      return;
    end
    p = 31;
    while (((m >> p) & 64'd1) == 0) p--;
    lzc = 31 - p;
    lat = fast ? (lzc / 8 + lzc % 8 + 2) : (lzc + 2);
    if (p > 23) begin
      sh   = p - 23;
      q    = m >> sh;
      rem  = m - (q << sh);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && q[0])) q++;
      inx = (rem != 0);
    end else begin
      q   = m << (23 - p);
      inx = 1'b0;
    end
    if (q == (64'd1 << 24)) begin
      q = q >> 1;
      p++;
    end
    res = {neg, 8'(127 + p), q[22:0]};
  endfunction

  // Called right after a negedge with the selected instance idle.
  task automatic run_op(input bit fast, input logic [31:0] op, input bit sg,
                        output logic [31:0] res, output logic inx, output int lat);
    sel = fast;
    check("in_ready_idle", {31'd0, in_ready_o}, 32'd1);
    int_operand = op;
    is_signed   = sg;
    in_valid    = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    in_valid = 1'b0;
    lat = 0;
    do begin
      @(posedge CLK);
      lat++;
      @(negedge CLK);
    end while (!out_valid_o && lat < 60);
    if (!out_valid_o) check("out_valid_timeout", 32'd0, 32'd1);
    res = float_result_o;
    inx = inexact_o;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    out_ready = 1'b0;
    check("out_valid_drop", {31'd0, out_valid_o}, 32'd0);
    check("in_ready_back", {31'd0, in_ready_o}, 32'd1);
  endtask

  typedef struct {
    logic [31:0] op;
    bit          sg;
    bit          fast;
    logic [31:0] res;
    bit          inx;
    int          lat;
  } vec_t;

  vec_t vecs[10] = '{
    '{32'h0000_0001, 1'b1, 1'b0, 32'h3F80_0000, 1'b0, 33},
    '{32'hFFFF_FFFF, 1'b1, 1'b0, 32'hBF80_0000, 1'b0, 33},
    '{32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1},
    '{32'h8000_0000, 1'b1, 1'b0, 32'hCF00_0000, 1'b0, 2},
    '{32'h8000_0000, 1'b0, 1'b0, 32'h4F00_0000, 1'b0, 2},
    '{32'h0100_0001, 1'b0, 1'b0, 32'h4B80_0000, 1'b1, 9},
    '{32'h0100_0003, 1'b0, 1'b0, 32'h4B80_0002, 1'b1, 9},
    '{32'hFFFF_FFFF, 1'b0, 1'b0, 32'h4F80_0000, 1'b1, 2},
    '{32'h0000_0001, 1'b1, 1'b1, 32'h3F80_0000, 1'b0, 12},
    '{32'h0000_0064, 1'b1, 1'b0, 32'h42C8_0000, 1'b0, 27}
  };

  initial begin
    logic [31:0] res, exp_res, held;
    logic        inx, held_inx;
    bit          exp_inx;
    int          lat, exp_lat;
    logic [31:0] op;
    bit          sg;

    repeat (2) @(posedge CLK);
    @(negedge CLK);
    for (int m = 0; m < 2; m++) begin
      sel = (m == 1);
      check("rst_in_ready", {31'd0, in_ready_o}, 32'd1);
      check("rst_out_valid", {31'd0, out_valid_o}, 32'd0);
      check("rst_float_result", float_result_o, 32'd0);
      check("rst_inexact", {31'd0, inexact_o}, 32'd0);
    end
    RESET = 1'b0;
    @(negedge CLK);

    foreach (vecs[i]) begin
      run_op(vecs[i].fast, vecs[i].op, vecs[i].sg, res, inx, lat);
      check($sformatf("dir%0d_result", i), res, vecs[i].res);
      check($sformatf("dir%0d_inexact", i), {31'd0, inx}, {31'd0, vecs[i].inx});
      check($sformatf("dir%0d_latency", i), lat, vecs[i].lat);
      consume();
    end

    // backpressure: result must hold and new operands must be refused
    run_op(1'b0, 32'h0100_0003, 1'b0, held, held_inx, lat);
    for (int c = 0; c < 10; c++) begin
      int_operand = $urandom();
      is_signed   = 1'(c);
      in_valid    = ~in_valid;
      @(posedge CLK);
      @(negedge CLK);
      check("bp_result", float_result_o, 32'h4B80_0002);
      check("bp_inexact", {31'd0, inexact_o}, 32'd1);
      check("bp_out_valid", {31'd0, out_valid_o}, 32'd1);
      check("bp_in_ready", {31'd0, in_ready_o}, 32'd0);
    end
    in_valid = 1'b0;
    consume();
    run_op(1'b0, 32'hFFFF_FFFF, 1'b1, res, inx, lat);
    check("post_bp_result", res, 32'hBF80_0000);
    consume();

    // reset in the middle of normalisation
    sel = 1'b0;
    int_operand = 32'd1;
    is_signed   = 1'b1;
    in_valid    = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    in_valid = 1'b0;
    repeat (4) @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    check("midrst_out_valid", {31'd0, out_valid_o}, 32'd0);
    check("midrst_in_ready", {31'd0, in_ready_o}, 32'd1);
    check("midrst_result", float_result_o, 32'd0);
    repeat (40) begin
      @(posedge CLK);
      @(negedge CLK);
      if (out_valid_o) break;
    end
    check("midrst_no_ghost", {31'd0, out_valid_o}, 32'd0);
    run_op(1'b0, 32'd100, 1'b1, res, inx, lat);
    check("midrst_100", res, 32'h42C8_0000);
    consume();

    // random operands in both modes against the reference model
    for (int m = 0; m < 2; m++) begin
      for (int n = 0; n < 1000; n++) begin
        op = $urandom() >> $urandom_range(0, 31);
        if ($urandom_range(0, 49) == 0) op = 32'd0;
        sg = 1'($urandom());
        ref_model(op, sg, (m == 1), exp_res, exp_inx, exp_lat);
        run_op((m == 1), op, sg, res, inx, lat);
        check($sformatf("rnd_result op=%h s=%0d f=%0d", op, sg, m), res, exp_res);
        check($sformatf("rnd_inexact op=%h s=%0d f=%0d", op, sg, m), {31'd0, inx}, {31'd0, exp_inx});
        check($sformatf("rnd_latency op=%h s=%0d f=%0d", op, sg, m), lat, exp_lat);
        consume();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
